// File: rtl/contador_rolhas_bcd.sv
// contador_rolhas_bcd
// Sequential front end for the 4-digit multiplexed display of the corking
// machine: digit-scan counter/enable plus BCD counters for sealed dozens
// (00-99) and corks in stock (00-99).
//
// Parameters:
//   PRESCALE     clock cycles per scan step (>= 2)
//   CARGA        corks added per reload event (1..15, binary)
//   ROLHAS_RESET BCD cork stock after reset
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ligado                           machine on; gates counting and scan
//   garrafa_vedada                   rising edge = one bottle sealed
//   carga_rolhas                     rising edge = CARGA corks loaded
//   zerar_duzias                     level; clears dozens, bottle count, flag
//   contador                         digit-scan select 0..3
//   display_en                       registered copy of ligado
//   duzias_dezenas/duzias_unidades   BCD dozens
//   rolhas_dezenas/rolhas_unidades   BCD cork stock
//   rolhas_vazio                     stock == 00
//   duzias_max                       sticky, dozens saturated at 99
//
// Optional macro BLANK_ZERO_EN: the tens digits output 4'hF (blank code)
// when they are 0; internal state is unaffected.

module contador_rolhas_bcd #(
  parameter int unsigned PRESCALE     = 50000,
  parameter logic [3:0]  CARGA        = 4'd12,
  parameter logic [7:0]  ROLHAS_RESET = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ligado,
  input  logic       garrafa_vedada,
  input  logic       carga_rolhas,
  input  logic       zerar_duzias,
  output logic [1:0] contador,
  output logic       display_en,
  output logic [3:0] duzias_dezenas,
  output logic [3:0] duzias_unidades,
  output logic [3:0] rolhas_dezenas,
  output logic [3:0] rolhas_unidades,
  output logic       rolhas_vazio,
  output logic       duzias_max
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    contador_q, contador_d;
  logic          display_en_q, display_en_d;
  logic          garrafa_prev_q, garrafa_prev_d;
  logic          carga_prev_q, carga_prev_d;
  logic [3:0]    duz_dez_q, duz_dez_d;
  logic [3:0]    duz_uni_q, duz_uni_d;
  logic [3:0]    garrafas_q, garrafas_d;
  logic [3:0]    rol_dez_q, rol_dez_d;
  logic [3:0]    rol_uni_q, rol_uni_d;
  logic          duz_max_q, duz_max_d;

  logic       garrafa_ev;
  logic       carga_ev;
  logic       garrafa_ok;
  logic [3:0] rol_t;
  logic [3:0] rol_u;
  logic [4:0] soma;

  always_comb begin
    prescaler_d    = prescaler_q;
    contador_d     = contador_q;
    duz_dez_d      = duz_dez_q;
    duz_uni_d      = duz_uni_q;
    garrafas_d     = garrafas_q;
    duz_max_d      = duz_max_q;
    garrafa_ok     = 1'b0;
    soma           = '0;

    garrafa_prev_d = garrafa_vedada;
    carga_prev_d   = carga_rolhas;
    display_en_d   = ligado;

    garrafa_ev = ligado & garrafa_vedada & ~garrafa_prev_q;
    carga_ev   = ligado & carga_rolhas & ~carga_prev_q;

    // Scan
    if (!ligado) begin
      prescaler_d = '0;
      contador_d  = '0;
    end else if (prescaler_q == PW'(PRESCALE - 1)) begin
      prescaler_d = '0;
      contador_d  = contador_q + 2'd1;
    end else begin
      prescaler_d = prescaler_q + PW'(1);
    end

    // Reload is applied before the bottle so a simultaneous pair sees the
    // refilled stock. Units sum is at most 9+15=24, so at most two carries.
    rol_t = rol_dez_q;
    rol_u = rol_uni_q;
    if (carga_ev) begin
      soma = {1'b0, rol_u} + {1'b0, CARGA};
      if (soma >= 5'd20) begin
        rol_u = 4'(soma - 5'd20);
        rol_t = rol_t + 4'd2;
      end else if (soma >= 5'd10) begin
        rol_u = 4'(soma - 5'd10);
        rol_t = rol_t + 4'd1;
      end else begin
        rol_u = soma[3:0];
      end
      if (rol_t > 4'd9) begin
        rol_t = 4'd9;
        rol_u = 4'd9;
      end
    end

    if (garrafa_ev && ((rol_t != 4'd0) || (rol_u != 4'd0))) begin
      garrafa_ok = 1'b1;
      if (rol_u == 4'd0) begin
        rol_u = 4'd9;
        rol_t = rol_t - 4'd1;
      end else begin
        rol_u = rol_u - 4'd1;
      end
    end

    rol_dez_d = rol_t;
    rol_uni_d = rol_u;

    // Dozens: clearing wins over a counted bottle; stock still decrements.
    if (ligado && zerar_duzias) begin
      duz_dez_d  = '0;
      duz_uni_d  = '0;
      garrafas_d = '0;
      duz_max_d  = 1'b0;
    end else if (garrafa_ok) begin
      if (garrafas_q == 4'd11) begin
        garrafas_d = '0;
        if ((duz_dez_q == 4'd9) && (duz_uni_q == 4'd9)) begin
          duz_max_d = 1'b1;
        end else if (duz_uni_q == 4'd9) begin
          duz_uni_d = '0;
          duz_dez_d = duz_dez_q + 4'd1;
        end else begin
          duz_uni_d = duz_uni_q + 4'd1;
        end
      end else begin
        garrafas_d = garrafas_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q    <= '0;
      contador_q     <= '0;
      display_en_q   <= 1'b0;
      garrafa_prev_q <= 1'b0;
      carga_prev_q   <= 1'b0;
      duz_dez_q      <= '0;
      duz_uni_q      <= '0;
      garrafas_q     <= '0;
      rol_dez_q      <= ROLHAS_RESET[7:4];
      rol_uni_q      <= ROLHAS_RESET[3:0];
      duz_max_q      <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      contador_q     <= contador_d;
      display_en_q   <= display_en_d;
      garrafa_prev_q <= garrafa_prev_d;
      carga_prev_q   <= carga_prev_d;
      duz_dez_q      <= duz_dez_d;
      duz_uni_q      <= duz_uni_d;
      garrafas_q     <= garrafas_d;
      rol_dez_q      <= rol_dez_d;
      rol_uni_q      <= rol_uni_d;
      duz_max_q      <= duz_max_d;
    end
  end

  assign contador        = contador_q;
  assign display_en      = display_en_q;
  assign duzias_unidades = duz_uni_q;
  assign rolhas_unidades = rol_uni_q;
  assign rolhas_vazio    = (rol_dez_q == 4'd0) && (rol_uni_q == 4'd0);
  assign duzias_max      = duz_max_q;

`ifdef BLANK_ZERO_EN
  assign duzias_dezenas  = (duz_dez_q == 4'd0) ? 4'hF : duz_dez_q;
  assign rolhas_dezenas  = (rol_dez_q == 4'd0) ? 4'hF : rol_dez_q;
`else
  assign duzias_dezenas  = duz_dez_q;
  assign rolhas_dezenas  = rol_dez_q;
`endif

endmodule
